// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register chain of DEPTH stages with stall, flush, valid gating
// and a saturating counter of bubble cycles seen at the output.
module id_ex_pipe_reg #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ALUOP_W = 4,
   parameter int unsigned QTR_W   = 2,
   parameter int unsigned DEPTH   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  readData0,
   input  logic [DATA_W-1:0]  readData1,
   input  logic [DATA_W-1:0]  DataIn,
   input  logic [ALUOP_W-1:0] ALUOp,
   input  logic               ReadMem,
   input  logic               WriteMem,
   input  logic               write,
   input  logic [QTR_W-1:0]   quarter,
   input  logic               bubble_clr,
   output logic [DATA_W-1:0]  o_readData0,
   output logic [DATA_W-1:0]  o_readData1,
   output logic [DATA_W-1:0]  o_DataIn,
   output logic [ALUOP_W-1:0] o_ALUOp,
   output logic [QTR_W-1:0]   o_quarter,
   output logic               o_ReadMem,
   output logic               o_WriteMem,
   output logic               o_write,
   output logic               o_valid,
   output logic [7:0]         bubble_cnt
);

   localparam int unsigned LAST = DEPTH - 1;

   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("id_ex_pipe_reg: DEPTH must be in 1..4");
   end

   logic               r_valid [DEPTH];
   logic [DATA_W-1:0]  r_rd0   [DEPTH];
   logic [DATA_W-1:0]  r_rd1   [DEPTH];
   logic [DATA_W-1:0]  r_din   [DEPTH];
   logic [ALUOP_W-1:0] r_alu   [DEPTH];
   logic [QTR_W-1:0]   r_qtr   [DEPTH];
   logic               r_rm    [DEPTH];
   logic               r_wm    [DEPTH];
   logic               r_wr    [DEPTH];
   logic [7:0]         r_bubble_cnt;

   logic [DATA_W-1:0]  w_rd0;
   logic [DATA_W-1:0]  w_rd1;
   logic [DATA_W-1:0]  w_din;
   logic [ALUOP_W-1:0] w_alu;
   logic [QTR_W-1:0]   w_qtr;
   logic               w_rm;
   logic               w_wm;
   logic               w_wr;

   // A bubble enters stage 0 as an all-zero entry with enables forced off.
   assign w_rd0 = in_valid ? readData0 : '0;
   assign w_rd1 = in_valid ? readData1 : '0;
   assign w_din = in_valid ? DataIn    : '0;
   assign w_alu = in_valid ? ALUOp     : '0;
   assign w_qtr = in_valid ? quarter   : '0;
   assign w_rm  = ReadMem  & in_valid;
   assign w_wm  = WriteMem & in_valid;
   assign w_wr  = write    & in_valid;

   // Stage chain: flush clears everything, stall holds, otherwise shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            r_valid[k] <= 1'b0;
            r_rd0[k]   <= '0;
            r_rd1[k]   <= '0;
            r_din[k]   <= '0;
            r_alu[k]   <= '0;
            r_qtr[k]   <= '0;
            r_rm[k]    <= 1'b0;
            r_wm[k]    <= 1'b0;
            r_wr[k]    <= 1'b0;
         end
      end else if (!stall) begin
         r_valid[0] <= in_valid;
         r_rd0[0]   <= w_rd0;
         r_rd1[0]   <= w_rd1;
         r_din[0]   <= w_din;
         r_alu[0]   <= w_alu;
         r_qtr[0]   <= w_qtr;
         r_rm[0]    <= w_rm;
         r_wm[0]    <= w_wm;
         r_wr[0]    <= w_wr;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_rd0[k]   <= r_rd0[k-1];
            r_rd1[k]   <= r_rd1[k-1];
            r_din[k]   <= r_din[k-1];
            r_alu[k]   <= r_alu[k-1];
            r_qtr[k]   <= r_qtr[k-1];
            r_rm[k]    <= r_rm[k-1];
            r_wm[k]    <= r_wm[k-1];
            r_wr[k]    <= r_wr[k-1];
         end
      end
   end

   // Counts edges where the output held a bubble; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble_cnt <= 8'd0;
      end else if (bubble_clr) begin
         r_bubble_cnt <= 8'd0;
      end else if (!r_valid[LAST] && (r_bubble_cnt != 8'hFF)) begin
         r_bubble_cnt <= r_bubble_cnt + 8'd1;
      end
   end

   assign o_readData0 = r_rd0[LAST];
   assign o_readData1 = r_rd1[LAST];
   assign o_DataIn    = r_din[LAST];
   assign o_ALUOp     = r_alu[LAST];
   assign o_quarter   = r_qtr[LAST];
   assign o_ReadMem   = r_rm[LAST];
   assign o_WriteMem  = r_wm[LAST];
   assign o_write     = r_wr[LAST];
   assign o_valid     = r_valid[LAST];
   assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: DEPTH 1, 2 and 3 instances share one stimulus stream;
// a scoreboard queue per instance is checked by a negedge monitor.
module tb_id_ex_pipe_reg;

   typedef struct packed {
      logic [15:0] rd0;
      logic [15:0] rd1;
      logic [15:0] din;
      logic [3:0]  alu;
      logic [1:0]  q;
      logic        rm;
      logic        wm;
      logic        w;
   } exp_t;

   typedef struct {
      exp_t        p;
      int unsigned adv;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, in_valid, bubble_clr;
   logic [15:0] readData0, readData1, DataIn;
   logic [3:0]  ALUOp;
   logic [1:0]  quarter;
   logic        ReadMem, WriteMem, write;

   exp_t        w_act [3];
   logic        w_ov  [3];
   logic [7:0]  w_bc  [3];

   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [15:0] rd0, rd1, din;
      logic [3:0]  alu;
      logic [1:0]  q;
      logic        rm, wm, w, ov;
      logic [7:0]  bc;
      id_ex_pipe_reg #(.DATA_W(16), .ALUOP_W(4), .QTR_W(2), .DEPTH(g + 1)) u_dut (
         .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
         .readData0(readData0), .readData1(readData1), .DataIn(DataIn), .ALUOp(ALUOp),
         .ReadMem(ReadMem), .WriteMem(WriteMem), .write(write), .quarter(quarter),
         .bubble_clr(bubble_clr),
         .o_readData0(rd0), .o_readData1(rd1), .o_DataIn(din), .o_ALUOp(alu),
         .o_quarter(q), .o_ReadMem(rm), .o_WriteMem(wm), .o_write(w),
         .o_valid(ov), .bubble_cnt(bc)
      );
      assign w_act[g] = {rd0, rd1, din, alu, q, rm, wm, w};
      assign w_ov[g]  = ov;
      assign w_bc[g]  = bc;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: valid bits per stage, bubble counters and pending payloads.
   logic        mv   [3][4];
   logic [7:0]  ebc  [3];
   logic        nout [3];
   int unsigned adv;
   sb_t         q0[$], q1[$], q2[$];
   exp_t        last_p [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 4; s++) mv[d][s] <= 1'b0;
            ebc[d]  <= 8'd0;
            nout[d] <= 1'b0;
         end
         adv <= 0;
         q0.delete(); q1.delete(); q2.delete();
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (bubble_clr)                         ebc[d] <= 8'd0;
            else if (!mv[d][d] && ebc[d] != 8'hFF)  ebc[d] <= ebc[d] + 8'd1;
         end
         if (flush) begin
            for (int d = 0; d < 3; d++) begin
               for (int s = 0; s < 4; s++) mv[d][s] <= 1'b0;
               nout[d] <= 1'b0;
            end
            q0.delete(); q1.delete(); q2.delete();
         end else if (stall) begin
            for (int d = 0; d < 3; d++) nout[d] <= 1'b0;
         end else begin
            sb_t e;
            adv <= adv + 1;
            for (int d = 0; d < 3; d++) begin
               logic src;
               src = (d == 0) ? in_valid : mv[d][(d == 0) ? 0 : d - 1];
               mv[d][0] <= in_valid;
               for (int s = 1; s <= d; s++) mv[d][s] <= mv[d][s-1];
               nout[d] <= src;
            end
            if (in_valid) begin
               e.p   = '{readData0, readData1, DataIn, ALUOp, quarter,
                         ReadMem & in_valid, WriteMem & in_valid, write & in_valid};
               e.adv = adv + 1;
               q0.push_back(e); q1.push_back(e); q2.push_back(e);
            end
         end
      end
   end

   task automatic pop(input int d, output bit ok, output sb_t e);
      ok = 1'b1;
      case (d)
         0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
         1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
         default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
      endcase
   endtask

   // Monitor: new output pops the scoreboard; held output must not change; bubbles are zero.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            sb_t e;
            bit  ok;
            chk($sformatf("d%0d_valid", d + 1), 64'(w_ov[d]), 64'(mv[d][d]));
            chk($sformatf("d%0d_bubble_cnt", d + 1), 64'(w_bc[d]), 64'(ebc[d]));
            if (nout[d]) begin
               pop(d, ok, e);
               chk($sformatf("d%0d_sb_nonempty", d + 1), 64'(ok), 64'd1);
               if (ok) begin
                  chk($sformatf("d%0d_payload", d + 1), 64'(w_act[d]), 64'(e.p));
                  chk($sformatf("d%0d_latency", d + 1), 64'(adv - e.adv), 64'(d));
                  last_p[d] = e.p;
               end
            end else if (w_ov[d]) begin
               chk($sformatf("d%0d_held", d + 1), 64'(w_act[d]), 64'(last_p[d]));
            end else begin
               chk($sformatf("d%0d_bubble_zero", d + 1), 64'(w_act[d]), 64'd0);
            end
         end
      end
   end

   task automatic step(input logic iv, input logic [15:0] a, b, c, input logic [3:0] op,
                       input logic [1:0] qq, input logic rm, wm, w,
                       input logic st, fl, clr);
      in_valid = iv; readData0 = a; readData1 = b; DataIn = c; ALUOp = op; quarter = qq;
      ReadMem = rm; WriteMem = wm; write = w; stall = st; flush = fl; bubble_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic ins(input logic [15:0] a, b, c, input logic [3:0] op, input logic [1:0] qq,
                      input logic rm, wm, w);
      step(1'b1, a, b, c, op, qq, rm, wm, w, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic bub(input int n);
      repeat (n) step(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_d%0d_valid", tag, d + 1), 64'(w_ov[d]), 64'd0);
         chk($sformatf("%s_d%0d_bc", tag, d + 1), 64'(w_bc[d]), 64'd0);
         chk($sformatf("%s_d%0d_payload", tag, d + 1), 64'(w_act[d]), 64'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; bubble_clr = 1'b0;
      readData0 = '0; readData1 = '0; DataIn = '0; ALUOp = '0; quarter = '0;
      ReadMem = 1'b0; WriteMem = 1'b0; write = 1'b0;
      #1;
      chk_all_zero("reset");
      #11 rst_n = 1'b1;
      bub(2);

      // DEPTH=2: single instruction appears after the second edge for one cycle.
      ins(16'h1234, 16'h0, 16'h0, 4'h3, 2'h0, 1'b0, 1'b0, 1'b1);
      chk("d2_lat_edge1_valid", 64'(w_ov[1]), 64'd0);
      bub(1);
      chk("d2_out_valid", 64'(w_ov[1]), 64'd1);
      chk("d2_out_rd0", 64'(w_act[1].rd0), 64'h1234);
      chk("d2_out_alu", 64'(w_act[1].alu), 64'h3);
      chk("d2_out_write", 64'(w_act[1].w), 64'd1);
      bub(1);
      chk("d2_one_cycle", 64'(w_ov[1]), 64'd0);
      bub(2);

      // Invalid capture with store data present must stay a zero bubble.
      step(1'b0, 16'h0, 16'h0, 16'hFFFF, 4'h0, 2'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("d1_inv_wm", 64'(w_act[0].wm), 64'd0);
      chk("d1_inv_din", 64'(w_act[0].din), 64'd0);
      chk("d1_inv_valid", 64'(w_ov[0]), 64'd0);
      bub(3);

      // DEPTH=3 stall of two cycles with A at the output, then B and C.
      ins(16'hA001, 16'h1111, 16'h2222, 4'h1, 2'h1, 1'b1, 1'b0, 1'b0);
      ins(16'hB002, 16'h3333, 16'h4444, 4'h2, 2'h2, 1'b0, 1'b1, 1'b0);
      ins(16'hC003, 16'h5555, 16'h6666, 4'h5, 2'h3, 1'b0, 1'b0, 1'b1);
      chk("d3_a_out", 64'(w_act[2].rd0), 64'hA001);
      step(1'b1, 16'hDEAD, 16'hBEEF, 16'h0F0F, 4'hF, 2'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("d3_stall1_a", 64'(w_act[2].rd0), 64'hA001);
      step(1'b1, 16'hDEAD, 16'hBEEF, 16'h0F0F, 4'hF, 2'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("d3_stall2_a", 64'(w_act[2].rd0), 64'hA001);
      bub(1);
      chk("d3_then_b", 64'(w_act[2].rd0), 64'hB002);
      bub(1);
      chk("d3_then_c", 64'(w_act[2].rd0), 64'hC003);
      chk("d3_c_write", 64'(w_act[2].w), 64'd1);
      bub(3);

      // Full DEPTH=3 with stall and flush together: flush wins.
      ins(16'h0101, 16'h0, 16'h0, 4'h4, 2'h0, 1'b1, 1'b0, 1'b0);
      ins(16'h0202, 16'h0, 16'h0, 4'h6, 2'h1, 1'b0, 1'b1, 1'b0);
      ins(16'h0303, 16'h0, 16'h0, 4'h7, 2'h2, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h0404, 16'h1, 16'h2, 4'h8, 2'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("d3_flush_valid", 64'(w_ov[2]), 64'd0);
      chk("d3_flush_en", 64'({w_act[2].rm, w_act[2].wm, w_act[2].w}), 64'd0);

      // Clear and bubble in the same cycle: clear wins.
      step(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("d3_clr_wins", 64'(w_bc[2]), 64'd0);
      // Stalled bubbles still count.
      step(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("d3_stall_bubble_cnt", 64'(w_bc[2]), 64'd2);

      // Plain flush mid-stream drops P and the flush-cycle input; R survives.
      ins(16'h5050, 16'h0, 16'h0, 4'h9, 2'h0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h6060, 16'h0, 16'h0, 4'hA, 2'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ins(16'h7070, 16'h7, 16'h8, 4'hB, 2'h2, 1'b1, 1'b1, 1'b0);
      bub(4);

      // Saturation at 255 and clear.
      bub(300);
      for (int d = 0; d < 3; d++) chk($sformatf("d%0d_sat", d + 1), 64'(w_bc[d]), 64'd255);
      step(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 2'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int d = 0; d < 3; d++) chk($sformatf("d%0d_clr", d + 1), 64'(w_bc[d]), 64'd0);

      // Asynchronous reset between edges with valid output, during stall and flush.
      bub(7);
      ins(16'h8888, 16'h0, 16'h0, 4'hC, 2'h3, 1'b0, 1'b0, 1'b1);
      ins(16'h9999, 16'h0, 16'h0, 4'hD, 2'h2, 1'b1, 1'b0, 1'b0);
      ins(16'hAAAA, 16'h0, 16'h0, 4'hE, 2'h1, 1'b0, 1'b1, 1'b0);
      chk("d3_pre_rst_valid", 64'(w_ov[2]), 64'd1);
      chk("d3_pre_rst_bc", 64'(w_bc[2]), 64'd10);
      #2;
      stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk);
      #3 rst_n = 1'b1;
      stall = 1'b0; flush = 1'b0;
      ins(16'hBBBB, 16'hCCCC, 16'hDDDD, 4'h2, 2'h1, 1'b1, 1'b0, 1'b1);
      chk("d1_post_rst_valid", 64'(w_ov[0]), 64'd1);
      chk("d1_post_rst_rd0", 64'(w_act[0].rd0), 64'hBBBB);
      bub(4);

      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      chk("q2_drained", 64'(q2.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
